// File: rtl/display_bank_pio.sv
// Avalon-MM seven-segment display bank: per-digit hex/raw decode, per-digit blink,
// global blanking and selectable segment polarity, with a registered out_port.
module display_bank_pio #(
    parameter int               NUM_DIGITS     = 4,
    parameter int               ADDR_W         = 3,
    parameter int               CNT_W          = 24,
    parameter bit               SEG_ACTIVE_LOW = 1'b1,
    parameter logic [CNT_W-1:0] BLINK_DIV_RST  = CNT_W'(12_500_000)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [8*NUM_DIGITS-1:0] out_port,
    output logic                    blink_phase
);

    localparam logic [ADDR_W-1:0]       CTRL_ADDR = ADDR_W'(NUM_DIGITS);
    localparam logic [ADDR_W-1:0]       DIV_ADDR  = ADDR_W'(NUM_DIGITS + 1);
    localparam logic [8*NUM_DIGITS-1:0] OUT_OFF   = {(8*NUM_DIGITS){SEG_ACTIVE_LOW}};

    logic [9:0]              digit_q [NUM_DIGITS];
    logic [9:0]              digit_d [NUM_DIGITS];
    logic                    enable_q, enable_d;
    logic [CNT_W-1:0]        div_q, div_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    phase_q, phase_d;
    logic [8*NUM_DIGITS-1:0] out_q, out_d;
    logic                    wr_en;
    logic                    unused_wdata;

    assign unused_wdata = ^writedata;

    // Active-high gfedcba pattern with DP in bit 7, before blanking/polarity.
    function automatic logic [7:0] digit_pattern(input logic [9:0] d);
        logic [6:0] hex;
        if (d[8]) begin
            return d[7:0];
        end
        case (d[3:0])
            4'h0: hex = 7'h3F;
            4'h1: hex = 7'h06;
            4'h2: hex = 7'h5B;
            4'h3: hex = 7'h4F;
            4'h4: hex = 7'h66;
            4'h5: hex = 7'h6D;
            4'h6: hex = 7'h7D;
            4'h7: hex = 7'h07;
            4'h8: hex = 7'h7F;
            4'h9: hex = 7'h6F;
            4'hA: hex = 7'h77;
            4'hB: hex = 7'h7C;
            4'hC: hex = 7'h39;
            4'hD: hex = 7'h5E;
            4'hE: hex = 7'h79;
            default: hex = 7'h71;
        endcase
        return {d[7], hex};
    endfunction

    always_comb begin
        wr_en    = chipselect & ~write_n;
        digit_d  = digit_q;
        enable_d = enable_q;
        div_d    = div_q;
        if (wr_en) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (address == ADDR_W'(i)) digit_d[i] = writedata[9:0];
            end
            if (address == CTRL_ADDR) enable_d = writedata[0];
            if (address == DIV_ADDR)  div_d    = writedata[CNT_W-1:0];
        end

        // A BLINK_DIV write restarts the blink cycle and beats a terminal-count toggle.
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (wr_en && address == DIV_ADDR) begin
            cnt_d   = writedata[CNT_W-1:0];
            phase_d = 1'b1;
        end else if (div_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == '0) begin
            cnt_d   = div_q;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q - 1'b1;
        end

        out_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            logic [7:0] seg;
            seg = (enable_q && (!digit_q[i][9] || phase_q)) ? digit_pattern(digit_q[i]) : 8'h00;
            out_d[8*i +: 8] = SEG_ACTIVE_LOW ? ~seg : seg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= 10'h100;
            enable_q <= 1'b1;
            div_q    <= BLINK_DIV_RST;
            cnt_q    <= BLINK_DIV_RST;
            phase_q  <= 1'b1;
            out_q    <= OUT_OFF;
        end else begin
            digit_q  <= digit_d;
            enable_q <= enable_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            out_q    <= out_d;
        end
    end

    always_comb begin
        readdata = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (address == ADDR_W'(i)) readdata = {22'b0, digit_q[i]};
        end
        if (address == CTRL_ADDR) readdata = {31'b0, enable_q};
        if (address == DIV_ADDR)  readdata = 32'(div_q);
    end

    assign out_port    = out_q;
    assign blink_phase = phase_q;

endmodule
